seq_generator: RTL and testbench

//  Parallel-in/serial-out pattern generator; the transmit side of the seq_detector bit stream.

---
 rtl/seq_generator_if.sv | 26 ++
 rtl/seq_generator.sv | 130 +++++++++++++
 tb/tb_seq_generator.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_generator_if.sv
// Handshake/bus bundle for the serial pattern generator: parallel load side in,
// serial bit stream and status out.
interface seq_generator_if #(
  parameter int N = 16
);
  logic [N-1:0] data_in;
  logic         load;
  logic         start;
  logic         hold;
  logic         repeat_en;
  logic         outp;
  logic         out_valid;
  logic         busy;
  logic         done;
  logic [7:0]   frame_cnt;

  modport master (
    output data_in, load, start, hold, repeat_en,
    input  outp, out_valid, busy, done, frame_cnt
  );

  modport slave (
    input  data_in, load, start, hold, repeat_en,
    output outp, out_valid, busy, done, frame_cnt
  );
endinterface

// File: rtl/seq_generator.sv
// Parallel-in/serial-out pattern generator: emits a double-buffered N-bit word MSB-first,
// with stall, seamless repeat frames and a modulo-256 completed-frame counter.
module seq_generator #(
  parameter int   N          = 16,
  parameter int   CW         = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  seq_generator_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t       r_state;
  state_t       w_next_state;

  logic [N-1:0] r_shadow;
  logic [N-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic         r_outp;
  logic         r_valid;
  logic [7:0]   r_frame_cnt;

  logic [N-1:0] w_shift_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic         w_outp_nxt;
  logic         w_valid_nxt;
  logic [7:0]   w_frame_cnt_nxt;
  logic         w_last;
  logic         w_advance;

  assign w_last    = (r_cnt == '0);
  assign w_advance = (r_state == S_SHIFT) && !bus.hold;

  // State register
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  // NOTE: a default assignment first in every combinational block prevents latch inference.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_advance && w_last && !bus.repeat_en) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath next values; frame reloads always read the shadow as it stood before this edge.
  always_comb begin
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_outp_nxt      = r_outp;
    w_valid_nxt     = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_outp_nxt = IDLE_LEVEL;
        if (bus.start) begin
          w_outp_nxt  = r_shadow[N-1];
          w_shift_nxt = r_shadow << 1;
          w_cnt_nxt   = LAST_IDX;
          w_valid_nxt = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_advance && !w_last) begin
          w_outp_nxt  = r_shift[N-1];
          w_shift_nxt = r_shift << 1;
          w_cnt_nxt   = r_cnt - 1'b1;
          w_valid_nxt = 1'b1;
        end else if (w_advance) begin
          w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          if (bus.repeat_en) begin
            w_outp_nxt  = r_shadow[N-1];
            w_shift_nxt = r_shadow << 1;
            w_cnt_nxt   = LAST_IDX;
            w_valid_nxt = 1'b1;
          end else begin
            w_outp_nxt = IDLE_LEVEL;
          end
        end
      end
      default: w_outp_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow    <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_outp      <= IDLE_LEVEL;
      r_valid     <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (bus.load) r_shadow <= bus.data_in;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_outp      <= w_outp_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // Outputs: busy/done decode the registered state, so they are glitch-free flop outputs.
  always_comb begin
    bus.outp      = r_outp;
    bus.out_valid = r_valid;
    bus.busy      = (r_state == S_SHIFT);
    bus.done      = (r_state == S_DONE);
    bus.frame_cnt = r_frame_cnt;
  end

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: a frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed stream, latency and frame-count expectations.
module tb_seq_generator;

  localparam int   N          = 16;
  localparam int   CW         = 4;
  localparam logic IDLE_LEVEL = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;
  logic cap[$];

  seq_generator_if #(.N(N)) bus ();

  seq_generator #(.N(N), .CW(CW), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a latched word plus the index of the bit currently on the line.
  logic [N-1:0] m_shadow = '0;
  logic [N-1:0] m_word   = '0;
  int           m_pos    = 0;
  bit           m_active = 1'b0;
  bit           m_done   = 1'b0;
  logic         m_valid  = 1'b0;
  logic         m_outp   = IDLE_LEVEL;
  logic [7:0]   m_frames = 8'd0;

  task automatic model_begin_frame();
    m_word   = m_shadow;
    m_pos    = 0;
    m_active = 1'b1;
    m_valid  = 1'b1;
    m_outp   = m_word[N-1];
  endtask

  task automatic model_step();
    if (!rst) begin
      m_shadow = '0; m_word = '0; m_pos = 0; m_active = 1'b0; m_done = 1'b0;
      m_valid = 1'b0; m_outp = IDLE_LEVEL; m_frames = 8'd0;
    end else begin
      if (m_active) begin
        if (bus.hold) begin
          m_valid = 1'b0;
        end else if (m_pos < N - 1) begin
          m_pos   = m_pos + 1;
          m_valid = 1'b1;
          m_outp  = m_word[N-1-m_pos];
        end else begin
          m_frames = m_frames + 8'd1;
          if (bus.repeat_en) begin
            model_begin_frame();
          end else begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_valid  = 1'b0;
            m_outp   = IDLE_LEVEL;
          end
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (bus.start) begin
        model_begin_frame();
      end
      if (bus.load) m_shadow = bus.data_in;
    end
  endtask

  always @(posedge clk or negedge rst) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      check("outp",      {31'd0, bus.outp},      {31'd0, m_outp});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      check("busy",      {31'd0, bus.busy},      {31'd0, m_active});
      check("done",      {31'd0, bus.done},      {31'd0, m_done});
      check("frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, m_frames});
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) cap.push_back(bus.outp);
  end

  function automatic logic [15:0] cap_word(input int base);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) begin
      w = {w[14:0], (base + i < cap.size()) ? cap[base+i] : 1'bx};
    end
    return w;
  endfunction

  // Starts a frame and steps negedges until done, applying per-cycle stimulus by cycle number.
  task automatic run_frame(input int limit, input int hold_at, input int hold_len,
                           input int load_at, input logic [15:0] load_val,
                           input int clr_rep_at, input int start_a, input int start_b,
                           output int cyc);
    bus.start = 1'b1;
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == start_a) || (cyc == start_b);
      bus.load  = (cyc == load_at);
      if (cyc == load_at) bus.data_in = load_val;
      bus.hold  = (hold_len > 0) && (cyc >= hold_at) && (cyc < hold_at + hold_len);
      if (cyc == clr_rep_at) bus.repeat_en = 1'b0;
      if (bus.done === 1'b1) break;
    end
    if (bus.done !== 1'b1) check("frame_timeout", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.load  = 1'b0;
    bus.hold  = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    bus.data_in = w;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  int cyc;

  initial begin
    bus.data_in   = '0;
    bus.load      = 1'b0;
    bus.start     = 1'b0;
    bus.hold      = 1'b0;
    bus.repeat_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_outp",  {31'd0, bus.outp}, {31'd0, IDLE_LEVEL});
    check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_fcnt",  {24'd0, bus.frame_cnt}, 32'd0);

    // T1: plain frame
    load_word(16'b0010110110010110);
    cap.delete();
    run_frame(40, 0, 0, 0, 16'h0, 0, 0, 0, cyc);
    check("t1_done_latency", cyc, 32'd17);
    check("t1_bits", cap.size(), 32'd16);
    check("t1_stream", {16'd0, cap_word(0)}, {16'd0, 16'b0010110110010110});
    check("t1_frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);
    check("t1_idle_outp", {31'd0, bus.outp}, {31'd0, IDLE_LEVEL});

    // T2: 3-cycle stall after bit 5
    cap.delete();
    run_frame(40, 5, 3, 0, 16'h0, 0, 0, 0, cyc);
    check("t2_done_latency", cyc, 32'd20);
    check("t2_bits", cap.size(), 32'd16);
    check("t2_stream", {16'd0, cap_word(0)}, {16'd0, 16'b0010110110010110});
    check("t2_frame_cnt", {24'd0, bus.frame_cnt}, 32'd2);

    // T3: repeat frames with a mid-frame shadow reload
    load_word(16'hA5A5);
    cap.delete();
    bus.repeat_en = 1'b1;
    run_frame(80, 0, 0, 3, 16'h00FF, 35, 0, 0, cyc);
    check("t3_done_latency", cyc, 32'd49);
    check("t3_bits", cap.size(), 32'd48);
    check("t3_frame1", {16'd0, cap_word(0)},  32'h0000A5A5);
    check("t3_frame2", {16'd0, cap_word(16)}, 32'h000000FF);
    check("t3_frame3", {16'd0, cap_word(32)}, 32'h000000FF);
    check("t3_frame_cnt", {24'd0, bus.frame_cnt}, 32'd5);

    // T4: load+start same edge, start ignored in SHIFT and DONE
    load_word(16'h0001);
    cap.delete();
    bus.data_in = 16'hFFFF;
    bus.load    = 1'b1;
    run_frame(40, 0, 0, 0, 16'h0, 0, 5, 17, cyc);
    check("t4_done_latency", cyc, 32'd17);
    check("t4_old_shadow", {16'd0, cap_word(0)}, 32'h00000001);
    @(negedge clk);
    check("t4_no_restart_busy", {31'd0, bus.busy}, 32'd0);
    check("t4_no_restart_valid", {31'd0, bus.out_valid}, 32'd0);
    cap.delete();
    run_frame(40, 0, 0, 0, 16'h0, 0, 0, 0, cyc);
    check("t4_new_shadow", {16'd0, cap_word(0)}, 32'h0000FFFF);
    check("t4_frame_cnt", {24'd0, bus.frame_cnt}, 32'd7);

    // T5: asynchronous reset mid-frame
    load_word(16'h1234);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_pre_busy", {31'd0, bus.busy}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check("t5_async_outp",  {31'd0, bus.outp}, {31'd0, IDLE_LEVEL});
    check("t5_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_async_busy",  {31'd0, bus.busy}, 32'd0);
    check("t5_async_fcnt",  {24'd0, bus.frame_cnt}, 32'd0);
    #2 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_stays_idle", {31'd0, bus.busy}, 32'd0);
    end
    cap.delete();
    run_frame(40, 0, 0, 0, 16'h0, 0, 0, 0, cyc);
    check("t5_bits", cap.size(), 32'd16);
    check("t5_shadow_zero", {16'd0, cap_word(0)}, 32'd0);
    check("t5_frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);

    // T6: 256 back-to-back frames wrap the counter
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    load_word(16'hC3A1);
    cap.delete();
    bus.repeat_en = 1'b1;
    run_frame(5000, 0, 0, 0, 16'h0, 4085, 0, 0, cyc);
    check("t6_done_latency", cyc, 32'd4097);
    check("t6_bits", cap.size(), 32'd4096);
    check("t6_last_frame", {16'd0, cap_word(4080)}, 32'h0000C3A1);
    check("t6_frame_cnt_wrap", {24'd0, bus.frame_cnt}, 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
